// File: rtl/bram_dp_be.sv
// ---------------------------------------------------------------------------
// bram_dp_be
//   True dual-port, byte-enabled block RAM used as the RV32I unified
//   instruction/data memory. Port A serves instruction fetch, port B serves
//   load/store. Both ports are byte-addressed and respond 1+OUT_REG cycles
//   after an accepted request.
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset (clears outputs, keeps contents)
//   en_x       port x access request
//   we_x       port x byte write enables (lane i = bits 8i+7:8i)
//   addr_x     port x byte address
//   din_x      port x write data
//   dout_x     port x read data (0 on error, holds when idle)
//   valid_x    one-cycle strobe qualifying dout_x/err_x
//   err_x      port x access was out of range or misaligned
//   collision  both ports wrote overlapping lanes of one row (aligned with
//              valid_a)
// ---------------------------------------------------------------------------
module bram_dp_be #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 8192,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                READ_MODE = 0,
  parameter int                OUT_REG   = 0,
  parameter int                INIT_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_a,
  input  logic [DATA_W/8-1:0]   we_a,
  input  logic [ADDR_W-1:0]     addr_a,
  input  logic [DATA_W-1:0]     din_a,
  output logic [DATA_W-1:0]     dout_a,
  output logic                  valid_a,
  output logic                  err_a,
  input  logic                  en_b,
  input  logic [DATA_W/8-1:0]   we_b,
  input  logic [ADDR_W-1:0]     addr_b,
  input  logic [DATA_W-1:0]     din_b,
  output logic [DATA_W-1:0]     dout_b,
  output logic                  valid_b,
  output logic                  err_b,
  output logic                  collision
);

  localparam int NB    = DATA_W / 8;
  localparam int LB    = (NB > 1) ? $clog2(NB) : 0;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Out of range below the base, past the last row, or not word aligned.
  function automatic logic addrErr(input logic [ADDR_W-1:0] addr);
    logic [ADDR_W-1:0] off;
    off = addr - BASE_ADDR;
    return (addr < BASE_ADDR) ||
           ((off >> LB) >= ADDR_W'(DEPTH)) ||
           ((addr & ADDR_W'(NB - 1)) != '0);
  endfunction

  function automatic logic [IDX_W-1:0] rowIdx(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> LB);
  endfunction

  // Power-up image of a row.
  function automatic logic [DATA_W-1:0] initWord(input logic [IDX_W-1:0] idx);
    if (INIT_MODE == 1) return DATA_W'(idx);
    else                return '0;
  endfunction

  function automatic logic [DATA_W-1:0] mergeLanes(input logic [DATA_W-1:0] oldWord,
                                                   input logic [DATA_W-1:0] newWord,
                                                   input logic [NB-1:0]     we);
    logic [DATA_W-1:0] res;
    res = oldWord;
    for (int l = 0; l < NB; l++) begin
      if (we[l]) res[8*l +: 8] = newWord[8*l +: 8];
    end
    return res;
  endfunction

  // The array is stored XOR-encoded against the power-up image, so a
  // zero-initialised RAM reads back as the INIT_MODE pattern without any
  // load logic. The encoding is lane-wise, so byte writes stay byte writes.
  logic [DATA_W-1:0] mem [DEPTH];

  logic              errA, errB;
  logic [IDX_W-1:0]  idxA, idxB;
  logic [DATA_W-1:0] initA, initB;
  logic [DATA_W-1:0] oldA, oldB;
  logic [DATA_W-1:0] mergedA, mergedB;
  logic              wrA, wrB;

  logic [DATA_W-1:0] doutA_q, doutA_d, doutB_q, doutB_d;
  logic              validA_q, validA_d, validB_q, validB_d;
  logic              errA_q, errA_d, errB_q, errB_d;
  logic              collision_q, collision_d;

  assign errA    = addrErr(addr_a);
  assign errB    = addrErr(addr_b);
  assign idxA    = rowIdx(addr_a);
  assign idxB    = rowIdx(addr_b);
  assign initA   = initWord(idxA);
  assign initB   = initWord(idxB);
  assign oldA    = mem[idxA] ^ initA;
  assign oldB    = mem[idxB] ^ initB;
  assign mergedA = mergeLanes(oldA, din_a, we_a);
  assign mergedB = mergeLanes(oldB, din_b, we_b);

  // Writes are blocked while reset is asserted and on errored accesses.
  assign wrA = rst_n & en_a & ~errA & (|we_a);
  assign wrB = rst_n & en_b & ~errB & (|we_b);

  // Port A is written after port B so it wins any lane both ports write
  // in the same row; disjoint lanes keep their own port's data.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NB; l++) begin
      if (wrB && we_b[l]) mem[idxB][8*l +: 8] <= din_b[8*l +: 8] ^ initB[8*l +: 8];
      if (wrA && we_a[l]) mem[idxA][8*l +: 8] <= din_a[8*l +: 8] ^ initA[8*l +: 8];
    end
  end

  // Response selection. Cross-port reads always see the pre-write word
  // because old* is taken before either write lands.
  always_comb begin
    validA_d = en_a;
    errA_d   = en_a & errA;
    doutA_d  = doutA_q;
    if (en_a) begin
      if (errA)                  doutA_d = '0;
      else if (!(|we_a))         doutA_d = oldA;
      else if (READ_MODE == 0)   doutA_d = oldA;
      else if (READ_MODE == 1)   doutA_d = mergedA;
    end

    validB_d = en_b;
    errB_d   = en_b & errB;
    doutB_d  = doutB_q;
    if (en_b) begin
      if (errB)                  doutB_d = '0;
      else if (!(|we_b))         doutB_d = oldB;
      else if (READ_MODE == 0)   doutB_d = oldB;
      else if (READ_MODE == 1)   doutB_d = mergedB;
    end

    collision_d = wrA & wrB & (idxA == idxB) & (|(we_a & we_b));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doutA_q     <= '0;
      validA_q    <= 1'b0;
      errA_q      <= 1'b0;
      doutB_q     <= '0;
      validB_q    <= 1'b0;
      errB_q      <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      doutA_q     <= doutA_d;
      validA_q    <= validA_d;
      errA_q      <= errA_d;
      doutB_q     <= doutB_d;
      validB_q    <= validB_d;
      errB_q      <= errB_d;
      collision_q <= collision_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : gOutReg
      logic [DATA_W-1:0] doutAOut_q, doutBOut_q;
      logic              validAOut_q, validBOut_q;
      logic              errAOut_q, errBOut_q;
      logic              collisionOut_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          doutAOut_q     <= '0;
          validAOut_q    <= 1'b0;
          errAOut_q      <= 1'b0;
          doutBOut_q     <= '0;
          validBOut_q    <= 1'b0;
          errBOut_q      <= 1'b0;
          collisionOut_q <= 1'b0;
        end else begin
          doutAOut_q     <= doutA_q;
          validAOut_q    <= validA_q;
          errAOut_q      <= errA_q;
          doutBOut_q     <= doutB_q;
          validBOut_q    <= validB_q;
          errBOut_q      <= errB_q;
          collisionOut_q <= collision_q;
        end
      end

      assign dout_a    = doutAOut_q;
      assign valid_a   = validAOut_q;
      assign err_a     = errAOut_q;
      assign dout_b    = doutBOut_q;
      assign valid_b   = validBOut_q;
      assign err_b     = errBOut_q;
      assign collision = collisionOut_q;
    end else begin : gNoOutReg
      assign dout_a    = doutA_q;
      assign valid_a   = validA_q;
      assign err_a     = errA_q;
      assign dout_b    = doutB_q;
      assign valid_b   = validB_q;
      assign err_b     = errB_q;
      assign collision = collision_q;
    end
  endgenerate

endmodule

// File: tb/tb_bram_dp_be.sv
// ---------------------------------------------------------------------------
// tb_bram_dp_be
//   Drives four bram_dp_be instances with identical stimulus:
//   instances 0..2 use READ_MODE 0/1/2 without output register, instance 3
//   uses READ_MODE 0 with OUT_REG=1. All memories evolve identically since
//   write behaviour does not depend on READ_MODE.
// ---------------------------------------------------------------------------
module tb_bram_dp_be;

  logic clk = 1'b0;
  logic rst_n;

  logic        enA, enB;
  logic [3:0]  weA, weB;
  logic [31:0] addrA, addrB, dinA, dinB;

  logic [31:0] doutA [4];
  logic [31:0] doutB [4];
  logic        validA [4];
  logic        validB [4];
  logic        errA [4];
  logic        errB [4];
  logic        coll [4];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        enA;
    logic [3:0]  weA;
    logic [31:0] addrA;
    logic [31:0] dinA;
    logic        enB;
    logic [3:0]  weB;
    logic [31:0] addrB;
    logic [31:0] dinB;
    logic [2:0][31:0] expA;
    logic [2:0][31:0] expB;
    logic        expValidA;
    logic        expErrA;
    logic        expValidB;
    logic        expErrB;
    logic        expColl;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : gDut
    bram_dp_be #(
      .READ_MODE((g == 3) ? 0 : g),
      .OUT_REG  ((g == 3) ? 1 : 0)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en_a     (enA),
      .we_a     (weA),
      .addr_a   (addrA),
      .din_a    (dinA),
      .dout_a   (doutA[g]),
      .valid_a  (validA[g]),
      .err_a    (errA[g]),
      .en_b     (enB),
      .we_b     (weB),
      .addr_b   (addrB),
      .din_b    (dinB),
      .dout_b   (doutB[g]),
      .valid_b  (validB[g]),
      .err_b    (errB[g]),
      .collision(coll[g])
    );
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic eA, input logic [3:0] wA, input logic [31:0] aA, input logic [31:0] dA,
                        input logic eB, input logic [3:0] wB, input logic [31:0] aB, input logic [31:0] dB,
                        input logic [31:0] xA0, input logic [31:0] xA1, input logic [31:0] xA2,
                        input logic [31:0] xB0, input logic [31:0] xB1, input logic [31:0] xB2,
                        input logic vA, input logic rA, input logic vB, input logic rB, input logic c);
    vec_t v;
    v.enA = eA; v.weA = wA; v.addrA = aA; v.dinA = dA;
    v.enB = eB; v.weB = wB; v.addrB = aB; v.dinB = dB;
    v.expA[0] = xA0; v.expA[1] = xA1; v.expA[2] = xA2;
    v.expB[0] = xB0; v.expB[1] = xB1; v.expB[2] = xB2;
    v.expValidA = vA; v.expErrA = rA; v.expValidB = vB; v.expErrB = rB; v.expColl = c;
    vecs.push_back(v);
  endtask

  task automatic setInputs(input logic eA, input logic [3:0] wA, input logic [31:0] aA, input logic [31:0] dA,
                           input logic eB, input logic [3:0] wB, input logic [31:0] aB, input logic [31:0] dB);
    enA = eA; weA = wA; addrA = aA; dinA = dA;
    enB = eB; weB = wB; addrB = aB; dinB = dB;
  endtask

  // Drives one request cycle and leaves time 1 unit after the sampling edge.
  task automatic applyStimulus(input vec_t v);
    setInputs(v.enA, v.weA, v.addrA, v.dinA, v.enB, v.weB, v.addrB, v.dinB);
    @(posedge clk);
    #1;
  endtask

  task automatic stepIdle();
    setInputs(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkCleared(input string tag, input int g);
    checkOutput($sformatf("%s.i%0d.doutA", tag, g), doutA[g], 32'h0);
    checkOutput($sformatf("%s.i%0d.doutB", tag, g), doutB[g], 32'h0);
    checkOutput($sformatf("%s.i%0d.validA", tag, g), 32'(validA[g]), 32'h0);
    checkOutput($sformatf("%s.i%0d.validB", tag, g), 32'(validB[g]), 32'h0);
    checkOutput($sformatf("%s.i%0d.errA", tag, g), 32'(errA[g]), 32'h0);
    checkOutput($sformatf("%s.i%0d.errB", tag, g), 32'(errB[g]), 32'h0);
    checkOutput($sformatf("%s.i%0d.coll", tag, g), 32'(coll[g]), 32'h0);
  endtask

  initial begin
    setInputs(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    for (int g = 0; g < 4; g++) checkCleared("reset", g);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Memory starts with word i = i; expected per READ_MODE 0/1/2.
    addVec(1'b1, 4'b0000, 'h10,   0,           1'b1, 4'b0000, 'h7FFC, 0,
           4, 4, 4, 'h1FFF, 'h1FFF, 'h1FFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 4'b0000, 0,      0,           1'b1, 4'b0011, 'h20,   'hAABBCCDD,
           4, 4, 4, 8, 'hCCDD, 'h1FFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    addVec(1'b0, 4'b0000, 0,      0,           1'b1, 4'b0000, 'h20,   0,
           4, 4, 4, 'hCCDD, 'hCCDD, 'hCCDD, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Same-row double write: lane3,2 from A (lane2 overlaps), lane1 from B.
    addVec(1'b1, 4'b1100, 'h40,   'h11223344,  1'b1, 4'b0110, 'h40,   'h55667788,
           'h10, 'h11220010, 4, 'h10, 'h00667710, 'hCCDD, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    addVec(1'b1, 4'b0000, 'h40,   0,           1'b0, 4'b0000, 0,      0,
           'h11227710, 'h11227710, 'h11227710, 'h10, 'h00667710, 'hCCDD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Errored writes: past DEPTH (aliases row 0) and misaligned (aliases row 4).
    addVec(1'b1, 4'b1111, 'h8000, 'hFFFFFFFF,  1'b1, 4'b1111, 'h13,   'hDEADBEEF,
           0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    addVec(1'b1, 4'b0000, 'h0,    0,           1'b1, 4'b0000, 'h10,   0,
           0, 0, 0, 4, 4, 4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Cross-port: A writes, B reads the same row and sees the old word.
    addVec(1'b1, 4'b1111, 'h24,   'hCAFEF00D,  1'b1, 4'b0000, 'h24,   0,
           9, 'hCAFEF00D, 0, 9, 9, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 4'b0000, 'h7FFC, 0,           1'b1, 4'b0000, 'h24,   0,
           'h1FFF, 'h1FFF, 'h1FFF, 'hCAFEF00D, 'hCAFEF00D, 'hCAFEF00D, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // Same row, disjoint lanes: no collision.
    addVec(1'b1, 4'b0001, 'h28,   'h000000AA,  1'b1, 4'b1000, 'h28,   'hBB000000,
           'hA, 'hAA, 'h1FFF, 'hA, 'hBB00000A, 'hCAFEF00D, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    // B has we set but en low: ignored.
    addVec(1'b1, 4'b0000, 'h28,   0,           1'b0, 4'b1111, 'h2C,   'h12345678,
           'hBB0000AA, 'hBB0000AA, 'hBB0000AA, 'hA, 'hBB00000A, 'hCAFEF00D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    addVec(1'b0, 4'b0000, 0,      0,           1'b1, 4'b0000, 'h2C,   0,
           'hBB0000AA, 'hBB0000AA, 'hBB0000AA, 'hB, 'hB, 'hB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    // Errored A write to same row as B write: no collision, B data lands.
    addVec(1'b1, 4'b1111, 'h31,   'h99999999,  1'b1, 4'b1111, 'h30,   'h77777777,
           0, 0, 0, 'hC, 'h77777777, 'hB, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    addVec(1'b1, 4'b0000, 'h30,   0,           1'b1, 4'b0000, 'h4,    0,
           'h77777777, 'h77777777, 'h77777777, 1, 1, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      for (int m = 0; m < 3; m++) begin
        checkOutput($sformatf("v%0d.m%0d.doutA", i, m), doutA[m], vecs[i].expA[m]);
        checkOutput($sformatf("v%0d.m%0d.doutB", i, m), doutB[m], vecs[i].expB[m]);
        checkOutput($sformatf("v%0d.m%0d.validA", i, m), 32'(validA[m]), 32'(vecs[i].expValidA));
        checkOutput($sformatf("v%0d.m%0d.errA", i, m), 32'(errA[m]), 32'(vecs[i].expErrA));
        checkOutput($sformatf("v%0d.m%0d.validB", i, m), 32'(validB[m]), 32'(vecs[i].expValidB));
        checkOutput($sformatf("v%0d.m%0d.errB", i, m), 32'(errB[m]), 32'(vecs[i].expErrB));
        checkOutput($sformatf("v%0d.m%0d.coll", i, m), 32'(coll[m]), 32'(vecs[i].expColl));
      end
    end

    // Output-register instance: back-to-back reads of rows 0,1,2.
    stepIdle();
    stepIdle();
    setInputs(1'b1, 4'b0, 32'h0, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    checkOutput("oreg.e1.validA", 32'(validA[3]), 32'h0);
    setInputs(1'b1, 4'b0, 32'h4, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    checkOutput("oreg.e2.validA", 32'(validA[3]), 32'h1);
    checkOutput("oreg.e2.doutA", doutA[3], 32'h0);
    setInputs(1'b1, 4'b0, 32'h8, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    checkOutput("oreg.e3.validA", 32'(validA[3]), 32'h1);
    checkOutput("oreg.e3.doutA", doutA[3], 32'h1);
    stepIdle();
    checkOutput("oreg.e4.validA", 32'(validA[3]), 32'h1);
    checkOutput("oreg.e4.doutA", doutA[3], 32'h2);
    stepIdle();
    checkOutput("oreg.e5.validA", 32'(validA[3]), 32'h0);
    checkOutput("oreg.e5.doutA", doutA[3], 32'h2);

    // Reset in the cycle after a request, with a write held during reset.
    setInputs(1'b1, 4'b0, 32'h4, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    checkOutput("rst.pre.doutA", doutA[0], 32'h1);
    checkOutput("rst.pre.validA", 32'(validA[0]), 32'h1);
    setInputs(1'b0, 4'b0, 32'h0, 32'h0, 1'b1, 4'b1111, 32'h0, 32'hFFFFFFFF);
    rst_n = 1'b0;
    #1;
    checkCleared("rst.mid", 0);
    checkCleared("rst.mid", 3);
    @(posedge clk); #1;
    setInputs(1'b0, 4'b0, 32'h0, 32'h0, 1'b0, 4'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    stepIdle();
    checkOutput("rst.post.validA0", 32'(validA[0]), 32'h0);
    checkOutput("rst.post.validA3", 32'(validA[3]), 32'h0);
    checkOutput("rst.post.doutA3", doutA[3], 32'h0);
    setInputs(1'b1, 4'b0, 32'h0, 32'h0, 1'b1, 4'b0, 32'h20, 32'h0);
    @(posedge clk); #1;
    checkOutput("rst.read.doutA", doutA[0], 32'h0);
    checkOutput("rst.read.validA", 32'(validA[0]), 32'h1);
    checkOutput("rst.read.doutB", doutB[0], 32'h0000CCDD);
    stepIdle();
    checkOutput("rst.read.oreg.doutA", doutA[3], 32'h0);
    checkOutput("rst.read.oreg.validA", 32'(validA[3]), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
